pipe_controller: RTL and testbench
==================================

// Module: pipe_controller
// PURPOSE
//  Pipelined successor of the single-cycle MIPS controller: decodes opcode/funct in ID
//  and carries control bundles through ID/EX, EX/MEM and MEM/WB registers.
//  Adds bubble insertion, flush, an optional extended-immediate opcode set and an
//  illegal-instruction flag. Sits between the instruction decode logic and the hazard unit.
// PARAMETERS
//  ALUCTRL_W  3  alu_control width (>=3); encodings zero-extended into upper bits
//  EXT_OPS    1  1 = also decode andi/ori/slti; 0 = those opcodes are illegal
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          asynchronous active-low reset
//  opcode_d       in   6          ID-stage instr[31:26]
//  funct_d        in   6          ID-stage instr[5:0]
//  flush_e        in   1          load a bubble (all-zero bundle) into ID/EX
//  stall_e        in   1          hold ID/EX; load a bubble into EX/MEM
//  jump_d         out  1          combinational, ID stage
//  branch_d       out  1          combinational, ID stage
//  alusrc_e       out  1          registered, EX stage
//  regdst_e       out  1          registered, EX stage
//  alu_control_e  out  ALUCTRL_W  registered, EX stage
//  regwrite_e     out  1          to hazard unit
//  memtoreg_e     out  1          to hazard unit
//  illegal_e      out  1          EX-stage instr undecodable
//  memwrite_m     out  1          MEM stage
//  memen_m        out  1          MEM stage; memory access enable
//  regwrite_m     out  1          MEM stage
//  memtoreg_m     out  1          MEM stage
//  regwrite_w     out  1          WB stage
//  memtoreg_w     out  1          WB stage
// BEHAVIOUR
//  Decode (combinational, ID). Control bundle {rw,rd,as,br,mw,mtr,j,me,alu}:
//   R-type 000000: rw,rd; alu by funct: add 100000->010, sub 100010->110,
//     and 100100->000, or 100101->001, slt 101010->111; other funct -> illegal
//   lw 100011: rw,as,mtr,me,alu=010.  sw 101011: as,mw,me,alu=010
//   beq 000100: br,alu=110.  addi 001000: rw,as,alu=010.  j 000010: j
//   EXT_OPS=1: andi 001100 rw,as,alu=000; ori 001101 rw,as,alu=001; slti 001010 rw,as,alu=111
//   Unknown opcode/funct: all controls 0, illegal=1 (never writes reg or memory).
//  Pipeline regs: ID/EX holds {rw,mtr,mw,me,as,rd,alu,illegal}; EX/MEM holds {rw,mtr,mw,me};
//   MEM/WB holds {rw,mtr}. Each stage = 1 cycle; decode->WB latency 3 cycles.
//  Priority at ID/EX: flush_e > stall_e > load decode. flush_e=1 and stall_e=1 together:
//   ID/EX cleared AND EX/MEM gets a bubble.
//  stall_e=1 only: ID/EX holds its value; EX/MEM loads zeros; MEM/WB advances normally.
//  MEM/WB always advances (no stall input downstream of EX).
//  Reset (rst_n=0, async): all pipeline regs 0 -> every registered output 0, illegal_e=0.
//   Deassertion is taken synchronously at the next edge. A reset mid-stream discards all
//   in-flight bundles. jump_d/branch_d follow opcode_d, including during reset.
//  Bubble = all-zero bundle = nop: no regwrite, no memory access, alu_control_e=0.
// TESTING
//  1. rst_n=0 mid-stream with lw in EX -> all registered outputs 0 in the same cycle, no clk edge needed
//  2. lw (100011) in ID, no stall -> +1: alusrc_e=1, alu_control_e=010; +2: memen_m=1,
//     memtoreg_m=1; +3: regwrite_w=1, memtoreg_w=1
//  3. R sub (funct 100010) -> regdst_e=1, alu_control_e=110; then sw -> memwrite_m=1, regwrite_m=0
//  4. add in EX, stall_e=1 for 2 cycles -> alu_control_e stays 010; EX/MEM shows 2 bubbles
//     (regwrite_m=0), then add reaches MEM once stall_e drops
//  5. flush_e=1 with beq in ID -> branch_d=1 that cycle; next cycle ID/EX all 0;
//     flush_e=1 & stall_e=1 -> ID/EX and EX/MEM both zero
//  6. opcode 001101 (ori) with EXT_OPS=0 -> illegal_e=1, regwrite_e=0; with EXT_OPS=1 -> alu_control_e=001;
//     funct 000111 R-type -> illegal_e=1

Source files
------------

// File: rtl/pipe_controller.sv
// Pipelined MIPS control unit: decodes opcode/funct in ID and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB with bubble, stall and flush handling.
module pipe_controller #(
   parameter int ALUCTRL_W = 3,
   parameter bit EXT_OPS   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [5:0]           opcode_d,
   input  logic [5:0]           funct_d,
   input  logic                 flush_e,
   input  logic                 stall_e,
   output logic                 jump_d,
   output logic                 branch_d,
   output logic                 alusrc_e,
   output logic                 regdst_e,
   output logic [ALUCTRL_W-1:0] alu_control_e,
   output logic                 regwrite_e,
   output logic                 memtoreg_e,
   output logic                 illegal_e,
   output logic                 memwrite_m,
   output logic                 memen_m,
   output logic                 regwrite_m,
   output logic                 memtoreg_m,
   output logic                 regwrite_w,
   output logic                 memtoreg_w
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       rw;
      logic       rd;
      logic       as;
      logic       br;
      logic       mw;
      logic       mtr;
      logic       j;
      logic       me;
      logic [2:0] alu;
      logic       illegal;
   } dec_t;

   typedef struct packed {
      logic                 rw;
      logic                 mtr;
      logic                 mw;
      logic                 me;
      logic                 as;
      logic                 rd;
      logic [ALUCTRL_W-1:0] alu;
      logic                 illegal;
   } idex_t;

   typedef struct packed {
      logic rw;
      logic mtr;
      logic mw;
      logic me;
   } exmem_t;

   typedef struct packed {
      logic rw;
      logic mtr;
   } memwb_t;

   dec_t   dec;
   idex_t  idex_d,  idex_q;
   exmem_t exmem_d, exmem_q;
   memwb_t memwb_d, memwb_q;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      dec = '0;
      unique case (opcode_d)
         OP_RTYPE: begin
            dec.rw = 1'b1;
            dec.rd = 1'b1;
            case (funct_d)
               6'b100000: dec.alu = ALU_ADD;
               6'b100010: dec.alu = ALU_SUB;
               6'b100100: dec.alu = ALU_AND;
               6'b100101: dec.alu = ALU_OR;
               6'b101010: dec.alu = ALU_SLT;
               default: begin
                  dec         = '0;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         OP_LW:   begin dec.rw = 1'b1; dec.as = 1'b1; dec.mtr = 1'b1; dec.me = 1'b1; dec.alu = ALU_ADD; end
         OP_SW:   begin dec.as = 1'b1; dec.mw = 1'b1; dec.me = 1'b1; dec.alu = ALU_ADD; end
         OP_BEQ:  begin dec.br = 1'b1; dec.alu = ALU_SUB; end
         OP_ADDI: begin dec.rw = 1'b1; dec.as = 1'b1; dec.alu = ALU_ADD; end
         OP_J:    dec.j = 1'b1;
         OP_ANDI, OP_ORI, OP_SLTI: begin
            if (EXT_OPS) begin
               dec.rw  = 1'b1;
               dec.as  = 1'b1;
               dec.alu = (opcode_d == OP_ANDI) ? ALU_AND :
                         (opcode_d == OP_ORI)  ? ALU_OR  : ALU_SLT;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   assign jump_d   = dec.j;
   assign branch_d = dec.br;

   // Flush wins over stall at ID/EX; a stall always pushes a bubble into EX/MEM.
   always_comb begin
      idex_d = idex_q;
      if (flush_e) begin
         idex_d = '0;
      end else if (!stall_e) begin
         idex_d.rw      = dec.rw;
         idex_d.mtr     = dec.mtr;
         idex_d.mw      = dec.mw;
         idex_d.me      = dec.me;
         idex_d.as      = dec.as;
         idex_d.rd      = dec.rd;
         idex_d.alu     = ALUCTRL_W'(dec.alu);
         idex_d.illegal = dec.illegal;
      end

      exmem_d = '0;
      if (!stall_e) begin
         exmem_d.rw  = idex_q.rw;
         exmem_d.mtr = idex_q.mtr;
         exmem_d.mw  = idex_q.mw;
         exmem_d.me  = idex_q.me;
      end

      memwb_d.rw  = exmem_q.rw;
      memwb_d.mtr = exmem_q.mtr;
   end

   // NOTE: state registers use non-blocking assignments so all stages advance together.
   // NOTE: the all-zero reset value is the bubble, so reset discards in-flight bundles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   assign alusrc_e      = idex_q.as;
   assign regdst_e      = idex_q.rd;
   assign alu_control_e = idex_q.alu;
   assign regwrite_e    = idex_q.rw;
   assign memtoreg_e    = idex_q.mtr;
   assign illegal_e     = idex_q.illegal;
   assign memwrite_m    = exmem_q.mw;
   assign memen_m       = exmem_q.me;
   assign regwrite_m    = exmem_q.rw;
   assign memtoreg_m    = exmem_q.mtr;
   assign regwrite_w    = memwb_q.rw;
   assign memtoreg_w    = memwb_q.mtr;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: two instances (extended ops on/off, 3- and 4-bit alu_control)
// compared every cycle against an instruction-tracking pipeline model and a decode table.
module tb_pipe_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode_d = '0;
   logic [5:0] funct_d = '0;
   logic       flush_e = 1'b0;
   logic       stall_e = 1'b0;

   logic       a_jump, a_branch, a_as, a_rd, a_rwe, a_mtre, a_ill, a_mw, a_me, a_rwm, a_mtrm, a_rww, a_mtrw;
   logic [2:0] a_alu;
   logic       b_jump, b_branch, b_as, b_rd, b_rwe, b_mtre, b_ill, b_mw, b_me, b_rwm, b_mtrm, b_rww, b_mtrw;
   logic [3:0] b_alu;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_controller #(.ALUCTRL_W(3), .EXT_OPS(1'b1)) u_ext (
      .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .funct_d(funct_d),
      .flush_e(flush_e), .stall_e(stall_e), .jump_d(a_jump), .branch_d(a_branch),
      .alusrc_e(a_as), .regdst_e(a_rd), .alu_control_e(a_alu), .regwrite_e(a_rwe),
      .memtoreg_e(a_mtre), .illegal_e(a_ill), .memwrite_m(a_mw), .memen_m(a_me),
      .regwrite_m(a_rwm), .memtoreg_m(a_mtrm), .regwrite_w(a_rww), .memtoreg_w(a_mtrw)
   );

   pipe_controller #(.ALUCTRL_W(4), .EXT_OPS(1'b0)) u_base (
      .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .funct_d(funct_d),
      .flush_e(flush_e), .stall_e(stall_e), .jump_d(b_jump), .branch_d(b_branch),
      .alusrc_e(b_as), .regdst_e(b_rd), .alu_control_e(b_alu), .regwrite_e(b_rwe),
      .memtoreg_e(b_mtre), .illegal_e(b_ill), .memwrite_m(b_mw), .memen_m(b_me),
      .regwrite_m(b_rwm), .memtoreg_m(b_mtrm), .regwrite_w(b_rww), .memtoreg_w(b_mtrw)
   );

   typedef struct packed {
      bit       rw, rd, as, br, mw, mtr, j, me;
      bit [2:0] alu;
      bit       ill;
   } ctl_t;

   typedef struct packed {
      bit       v;
      bit [5:0] op;
      bit [5:0] fn;
   } slot_t;

   typedef struct {
      bit [5:0] op;
      bit       is_r;
      bit [5:0] fn;
      bit       ext_only;
      ctl_t     ctl;
   } rule_t;

   rule_t rules[$];
   slot_t ex_s, mem_s, wb_s;

   function automatic void add_rule(bit [5:0] op, bit is_r, bit [5:0] fn, bit ext_only, bit [11:0] c);
      rule_t r;
      r.op = op; r.is_r = is_r; r.fn = fn; r.ext_only = ext_only; r.ctl = ctl_t'(c);
      rules.push_back(r);
   endfunction

   // Control word layout: rw rd as br mw mtr j me alu[2:0] ill.
   function automatic void build_rules();
      add_rule(6'h00, 1, 6'h20, 0, 12'b1100_0000_010_0);
      add_rule(6'h00, 1, 6'h22, 0, 12'b1100_0000_110_0);
      add_rule(6'h00, 1, 6'h24, 0, 12'b1100_0000_000_0);
      add_rule(6'h00, 1, 6'h25, 0, 12'b1100_0000_001_0);
      add_rule(6'h00, 1, 6'h2a, 0, 12'b1100_0000_111_0);
      add_rule(6'h23, 0, 6'h00, 0, 12'b1010_0101_010_0);
      add_rule(6'h2b, 0, 6'h00, 0, 12'b0010_1001_010_0);
      add_rule(6'h04, 0, 6'h00, 0, 12'b0001_0000_110_0);
      add_rule(6'h08, 0, 6'h00, 0, 12'b1010_0000_010_0);
      add_rule(6'h02, 0, 6'h00, 0, 12'b0000_0010_000_0);
      add_rule(6'h0c, 0, 6'h00, 1, 12'b1010_0000_000_0);
      add_rule(6'h0d, 0, 6'h00, 1, 12'b1010_0000_001_0);
      add_rule(6'h0a, 0, 6'h00, 1, 12'b1010_0000_111_0);
   endfunction

   function automatic ctl_t golden(slot_t s, bit ext);
      ctl_t c = '0;
      if (!s.v) return c;
      foreach (rules[i]) begin
         if (rules[i].op == s.op && (!rules[i].is_r || rules[i].fn == s.fn) &&
             (ext || !rules[i].ext_only))
            return rules[i].ctl;
      end
      c.ill = 1'b1;
      return c;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      ex_s = '0; mem_s = '0; wb_s = '0;
   endtask

   task automatic check_id(string tag);
      ctl_t g1 = golden({1'b1, opcode_d, funct_d}, 1'b1);
      ctl_t g0 = golden({1'b1, opcode_d, funct_d}, 1'b0);
      check({tag, "_id_ext"},  {a_jump, a_branch}, {g1.j, g1.br});
      check({tag, "_id_base"}, {b_jump, b_branch}, {g0.j, g0.br});
   endtask

   task automatic check_all(string tag);
      ctl_t e1 = golden(ex_s, 1'b1),  e0 = golden(ex_s, 1'b0);
      ctl_t m1 = golden(mem_s, 1'b1), m0 = golden(mem_s, 1'b0);
      ctl_t w1 = golden(wb_s, 1'b1),  w0 = golden(wb_s, 1'b0);
      check({tag, "_ex_ext"},  {a_as, a_rd, 1'b0, a_alu, a_rwe, a_mtre, a_ill},
                               {e1.as, e1.rd, 1'b0, e1.alu, e1.rw, e1.mtr, e1.ill});
      check({tag, "_ex_base"}, {b_as, b_rd, b_alu, b_rwe, b_mtre, b_ill},
                               {e0.as, e0.rd, 1'b0, e0.alu, e0.rw, e0.mtr, e0.ill});
      check({tag, "_mem_ext"},  {a_mw, a_me, a_rwm, a_mtrm}, {m1.mw, m1.me, m1.rw, m1.mtr});
      check({tag, "_mem_base"}, {b_mw, b_me, b_rwm, b_mtrm}, {m0.mw, m0.me, m0.rw, m0.mtr});
      check({tag, "_wb_ext"},  {a_rww, a_mtrw}, {w1.rw, w1.mtr});
      check({tag, "_wb_base"}, {b_rww, b_mtrw}, {w0.rw, w0.mtr});
   endtask

   // Inputs change just after a falling edge; outputs are checked at the next falling edge.
   task automatic drive(string tag, bit [5:0] op, bit [5:0] fn, bit fl, bit st);
      opcode_d = op; funct_d = fn; flush_e = fl; stall_e = st;
      #1 check_id(tag);
      @(posedge clk);
      if (!rst_n) begin
         clear_model();
      end else begin
         wb_s  = mem_s;
         mem_s = st ? slot_t'('0) : ex_s;
         if (fl)       ex_s = '0;
         else if (!st) ex_s = {1'b1, op, fn};
      end
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      bit [5:0] op_pool[10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h0c, 6'h0d, 6'h0a, 6'h00};
      bit [5:0] fn_pool[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h07};
      bit [5:0] rop, rfn;

      build_rules();
      clear_model();
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      // lw latency, then sub and sw
      drive("lw",   6'h23, 6'h00, 0, 0);
      check("lw_alusrc_e", a_as, 1'b1);
      check("lw_alu_e",    a_alu, 3'b010);
      drive("sub",  6'h00, 6'h22, 0, 0);
      check("lw_memen_m",  a_me, 1'b1);
      check("sub_regdst_e", a_rd, 1'b1);
      drive("sw",   6'h2b, 6'h00, 0, 0);
      check("lw_regwrite_w", a_rww, 1'b1);
      drive("add",  6'h00, 6'h20, 0, 0);
      check("sw_memwrite_m", {a_mw, a_rwm}, 2'b10);

      // stall with add in EX for two cycles
      drive("stall1", 6'h23, 6'h00, 0, 1);
      check("stall_alu_e",  a_alu, 3'b010);
      check("stall_rw_m",   a_rwm, 1'b0);
      drive("stall2", 6'h23, 6'h00, 0, 1);
      drive("unstall", 6'h23, 6'h00, 0, 0);
      check("add_rw_m", a_rwm, 1'b1);

      // flush with beq in ID, then flush and stall together
      opcode_d = 6'h04; flush_e = 1'b1;
      #1 check("beq_branch_d", a_branch, 1'b1);
      drive("flush", 6'h04, 6'h00, 1, 0);
      drive("flush_stall", 6'h23, 6'h00, 1, 1);
      check("fs_zero", {a_as, a_alu, a_rwe, a_me, a_rwm, a_mw}, '0);

      // extended-immediate and illegal funct
      drive("ori", 6'h0d, 6'h00, 0, 0);
      check("ori_base_ill", {b_ill, b_rwe}, 2'b10);
      check("ori_ext_alu",  a_alu, 3'b001);
      drive("badfn", 6'h00, 6'h07, 0, 0);
      check("badfn_ill", a_ill, 1'b1);

      // async reset with lw in EX
      drive("lw2", 6'h23, 6'h00, 0, 0);
      #2 rst_n = 1'b0;
      clear_model();
      #1 check_all("async_rst");
      opcode_d = 6'h02;
      #1 check("rst_jump_d", a_jump, 1'b1);
      drive("in_rst", 6'h23, 6'h00, 0, 0);
      rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            clear_model();
         end else begin
            rst_n = 1'b1;
         end
         rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 9)];
         rfn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
         drive($sformatf("rnd%0d", i), rop, rfn,
               $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
